// File: rtl/instr_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port and status of instr_encoder.
// The master drives the bundle; the slave (encoder) drives ready, memory write and status.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 6
) ();
   logic              In_Valid;
   logic              In_Ready;
   logic [1:0]        ImmSrc;
   logic [6:0]        Op;
   logic [2:0]        Funct3;
   logic [4:0]        Rd;
   logic [4:0]        Rs1;
   logic [4:0]        Rs2;
   logic [31:0]       Imm;
   logic              Mem_WE;
   logic [ADDR_W-1:0] Mem_Addr;
   logic [31:0]       Mem_WD;
   logic [ADDR_W:0]   Count;
   logic              Full;
   logic              Err;

   modport master (
      output In_Valid, ImmSrc, Op, Funct3, Rd, Rs1, Rs2, Imm,
      input  In_Ready, Mem_WE, Mem_Addr, Mem_WD, Count, Full, Err
   );

   modport slave (
      input  In_Valid, ImmSrc, Op, Funct3, Rd, Rs1, Rs2, Imm,
      output In_Ready, Mem_WE, Mem_Addr, Mem_WD, Count, Full, Err
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs I/S/B instruction fields and a range-checked immediate into RV32 words and writes
// them to instruction memory at an auto-incrementing address.
module instr_encoder #(
   parameter int unsigned ADDR_W = 6
) (
   input logic           clk,
   input logic           rst,
   input logic           Clr,
   instr_encoder_if.slave bus
);
   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StWrite = 2'd1;
   localparam logic [1:0] StFull  = 2'd2;

   localparam logic [ADDR_W:0] Capacity = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       wd_q, wd_d;
   logic              err_q, err_d;
   logic              rst_done_q;

   logic [31:0]       enc_word;
   logic              imm_ok;
   logic              accept;
   logic [ADDR_W:0]   count_inc;

   always_comb begin
      enc_word = '0;
      imm_ok   = 1'b0;
      case (bus.ImmSrc)
         2'b00: begin
            enc_word = {bus.Imm[11:0], bus.Rs1, bus.Funct3, bus.Rd, bus.Op};
            imm_ok   = (&bus.Imm[31:11]) | ~(|bus.Imm[31:11]);
         end
         2'b01: begin
            enc_word = {bus.Imm[11:5], bus.Rs2, bus.Rs1, bus.Funct3, bus.Imm[4:0], bus.Op};
            imm_ok   = (&bus.Imm[31:11]) | ~(|bus.Imm[31:11]);
         end
         2'b10: begin
            enc_word = {bus.Imm[12], bus.Imm[10:5], bus.Rs2, bus.Rs1, bus.Funct3,
                        bus.Imm[4:1], bus.Imm[11], bus.Op};
            imm_ok   = ((&bus.Imm[31:12]) | ~(|bus.Imm[31:12])) & ~bus.Imm[0];
         end
         default: imm_ok = 1'b0;
      endcase
   end

   // Ready is held low until the first edge with reset released.
   assign bus.In_Ready = (state_q == StIdle) && rst_done_q;
   assign accept       = bus.In_Valid && bus.In_Ready && !Clr;
   assign count_inc    = count_q + 1'b1;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      wd_d    = wd_q;
      err_d   = err_q;
      if (Clr) begin
         state_d = StIdle;
         addr_d  = '0;
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  if (imm_ok) begin
                     wd_d    = enc_word;
                     state_d = StWrite;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            StWrite: begin
               addr_d  = addr_q + 1'b1;
               count_d = count_inc;
               state_d = (count_inc == Capacity) ? StFull : StIdle;
            end
            StFull:  state_d = StFull;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         count_q    <= '0;
         wd_q       <= '0;
         err_q      <= 1'b0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         wd_q       <= wd_d;
         err_q      <= err_d;
         rst_done_q <= 1'b1;
      end
   end

   assign bus.Mem_WE   = (state_q == StWrite);
   assign bus.Full     = (state_q == StFull);
   assign bus.Mem_Addr = addr_q;
   assign bus.Mem_WD   = wd_q;
   assign bus.Count    = count_q;
   assign bus.Err      = err_q;
endmodule
